trivium_keystream_ctrl: RTL

//  Sequencer for the trivium keystream core. Latches key/IV on a start command, loads the core
//  and runs the WARMUP discard rounds. It then collects NWORDS keystream words of W bits each and

---
 rtl/trivium_keystream_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/trivium_keystream_ctrl.sv
// Trivium keystream sequencer: key/IV load, warm-up discard,
// W-bit word collection and valid/ready hand-off.
module trivium_keystream_ctrl #(
  parameter int W      = 8,
  parameter int WARMUP = 1152,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [79:0]      key,
  input  logic [79:0]      iv,
  input  logic [CNT_W-1:0] nwords,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [79:0]      core_key,
  output logic [79:0]      core_iv,
  output logic             core_load,
  output logic             core_step,
  input  logic             core_z
);

  localparam int WC_W = $clog2(WARMUP + 1);
  localparam int BC_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [WC_W-1:0] WLAST = WC_W'(WARMUP - 1);
  localparam logic [BC_W-1:0] BLAST = BC_W'(W - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, LOAD, WARM, GEN, HOLD, FIN
  } st_t;

  st_t st, nxt;
  logic [WC_W-1:0]  wcnt;
  logic [BC_W-1:0]  bcnt;
  logic [CNT_W-1:0] rem;
  logic             accept;
  logic             xfer;

  assign accept = (st == IDLE) && start &&
                  (nwords != '0) && !abort;
  assign xfer   = (st == HOLD) && out_ready && !abort;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= nxt;
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:    if (accept) nxt = LOAD;
      LOAD:    nxt = WARM;
      WARM:    if (wcnt == WLAST) nxt = GEN;
      GEN:     if (bcnt == BLAST) nxt = HOLD;
      HOLD:    if (xfer) nxt = (rem == ONE) ? FIN : GEN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  // Moore outputs decoded from the state
  always_comb begin
    busy      = 1'b1;
    done      = 1'b0;
    out_valid = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;
    unique case (st)
      IDLE:    busy = 1'b0;
      LOAD:    core_load = 1'b1;
      WARM:    core_step = 1'b1;
      GEN:     core_step = 1'b1;
      HOLD:    out_valid = 1'b1;
      FIN:     done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Operand latch, counters and word assembly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_key <= '0;
      core_iv  <= '0;
      rem      <= '0;
      wcnt     <= '0;
      bcnt     <= '0;
      out_data <= '0;
    end else begin
      if (accept) begin
        core_key <= key;
        core_iv  <= iv;
        rem      <= nwords;
      end
      if (abort || st != WARM) wcnt <= '0;
      else if (wcnt == WLAST)  wcnt <= '0;
      else                     wcnt <= wcnt + 1'b1;
      if (abort || st != GEN) bcnt <= '0;
      else begin
        out_data[bcnt] <= core_z;
        bcnt <= (bcnt == BLAST) ? '0 : bcnt + 1'b1;
      end
      if (xfer) rem <= rem - 1'b1;
    end
  end

endmodule
